keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_pkg.sv | 29 ++
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/keypad_scanner_tick_gen.sv | 29 ++
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the keypad scanner and its neighbours.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam logic [3:0] COL_IDLE = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  // Index of the lowest-numbered row pulled low; row 0 wins ties.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the key outputs consumed by the game FSM and sound block.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [3:0]       row_n;
  logic [3:0]       col_n;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             keypad_pressed;

  // Scanner side.
  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output keypad_pressed
  );

  // Keypad/consumer side.
  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  keypad_pressed
  );
endinterface

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_gen #(
  parameter int unsigned DIV = 27000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == W'(DIV - 1));
  assign tick   = w_wrap;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row synchroniser and press/release debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 27000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input logic              clk,
  input logic              rst_n,
  keypad_scanner_if.master kp
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_MS + 1);

  logic             w_tick;
  logic [3:0]       r_rows_meta;
  logic [3:0]       r_rows_s;
  kp_state_t        r_state,     w_state_d;
  logic [CntW-1:0]  r_cnt,       w_cnt_d;
  logic [1:0]       r_col_idx,   w_col_idx_d;
  logic [1:0]       r_row,       w_row_d;
  logic [3:0]       r_col_n,     w_col_n_d;
  logic [KEY_W-1:0] r_key_code,  w_key_code_d;
  logic             r_key_valid, w_key_valid_d;
  logic             r_pressed,   w_pressed_d;
  logic             w_row_low;
  logic [CntW-1:0]  w_cnt_inc;
  logic             w_cnt_done;

  tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_meta <= 4'hF;
      r_rows_s    <= 4'hF;
    end else begin
      r_rows_meta <= kp.row_n;
      r_rows_s    <= r_rows_meta;
    end
  end

  assign w_row_low  = ~r_rows_s[r_row];
  assign w_cnt_inc  = r_cnt + CntW'(1);
  assign w_cnt_done = (w_cnt_inc == CntW'(DEBOUNCE_MS));

  // Next-state and registered-output logic; everything moves only on tick.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_col_idx_d   = r_col_idx;
    w_row_d       = r_row;
    w_col_n_d     = r_col_n;
    w_key_code_d  = r_key_code;
    w_key_valid_d = 1'b0;
    w_pressed_d   = r_pressed;
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (r_rows_s != 4'hF) begin
            w_row_d = lowest_low_row(r_rows_s);
            if (DEBOUNCE_MS == 1) begin
              // Entry tick alone satisfies a one-tick debounce.
              w_state_d     = HELD;
              w_cnt_d       = '0;
              w_key_code_d  = {w_row_d, r_col_idx};
              w_key_valid_d = 1'b1;
              w_pressed_d   = 1'b1;
            end else begin
              w_state_d = DEBOUNCE;
              w_cnt_d   = CntW'(1);
            end
          end else begin
            w_col_idx_d = r_col_idx + 2'd1;
            w_col_n_d   = col_drive(r_col_idx + 2'd1);
          end
        end
        DEBOUNCE: begin
          if (w_row_low) begin
            if (w_cnt_done) begin
              w_state_d     = HELD;
              w_cnt_d       = '0;
              w_key_code_d  = {r_row, r_col_idx};
              w_key_valid_d = 1'b1;
              w_pressed_d   = 1'b1;
            end else begin
              w_cnt_d = w_cnt_inc;
            end
          end else begin
            w_state_d   = SCAN;
            w_cnt_d     = '0;
            w_col_idx_d = r_col_idx + 2'd1;
            w_col_n_d   = col_drive(r_col_idx + 2'd1);
          end
        end
        HELD: begin
          // Only the latched row matters; other rows are ignored.
          if (!w_row_low) begin
            if (DEBOUNCE_MS == 1) begin
              w_state_d   = SCAN;
              w_cnt_d     = '0;
              w_pressed_d = 1'b0;
              w_col_idx_d = r_col_idx + 2'd1;
              w_col_n_d   = col_drive(r_col_idx + 2'd1);
            end else begin
              w_state_d = RELEASE;
              w_cnt_d   = CntW'(1);
            end
          end
        end
        RELEASE: begin
          if (!w_row_low) begin
            if (w_cnt_done) begin
              w_state_d   = SCAN;
              w_cnt_d     = '0;
              w_pressed_d = 1'b0;
              w_col_idx_d = r_col_idx + 2'd1;
              w_col_n_d   = col_drive(r_col_idx + 2'd1);
            end else begin
              w_cnt_d = w_cnt_inc;
            end
          end else begin
            // Release bounce: back to HELD without a new key_valid.
            w_state_d = HELD;
            w_cnt_d   = '0;
          end
        end
        default: begin
          w_state_d = SCAN;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_col_idx   <= 2'd0;
      r_row       <= 2'd0;
      r_col_n     <= COL_IDLE;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_pressed   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_col_idx   <= w_col_idx_d;
      r_row       <= w_row_d;
      r_col_n     <= w_col_n_d;
      r_key_code  <= w_key_code_d;
      r_key_valid <= w_key_valid_d;
      r_pressed   <= w_pressed_d;
    end
  end

  assign kp.col_n          = r_col_n;
  assign kp.key_code       = r_key_code;
  assign kp.key_valid      = r_key_valid;
  assign kp.keypad_pressed = r_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  localparam int unsigned DIV = 10;
  localparam int unsigned DEB = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys;
  int          n_checks;
  int          n_fail;
  int          n_valid;
  int          v0;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV    (DIV),
    .DEBOUNCE_MS (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    kp.row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
      end
    end
  end

  // Count key_valid pulses.
  always @(posedge clk) begin
    if (kp.key_valid === 1'b1) n_valid++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_valid  = 0;
    keys     = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_n", 32'(kp.col_n), 32'hE);
    check("rst_code", 32'(kp.key_code), 32'h0);
    check("rst_valid", 32'(kp.key_valid), 32'h0);
    check("rst_pressed", 32'(kp.keypad_pressed), 32'h0);
    rst_n = 1'b1;

    // Idle scanning.
    step(1); check("scan_c1", 32'(kp.col_n), 32'hD);
    step(1); check("scan_c2", 32'(kp.col_n), 32'hB);
    step(1); check("scan_c3", 32'(kp.col_n), 32'h7);
    step(1); check("scan_c0", 32'(kp.col_n), 32'hE);
    check("idle_pressed", 32'(kp.keypad_pressed), 32'h0);
    check("idle_nvalid", 32'(n_valid), 32'd0);

    // Key 9 (row 2, col 1).
    keys[9] = 1'b1;
    step(1); check("k9_col_sel", 32'(kp.col_n), 32'hD);
    step(1); check("k9_frozen", 32'(kp.col_n), 32'hD);
    check("k9_pressed_early", 32'(kp.keypad_pressed), 32'h0);
    step(2); check("k9_valid_early", 32'(kp.key_valid), 32'h0);
    step(1); check("k9_valid", 32'(kp.key_valid), 32'h1);
    check("k9_code", 32'(kp.key_code), 32'd9);
    check("k9_pressed", 32'(kp.keypad_pressed), 32'h1);
    step(6); check("k9_held_col", 32'(kp.col_n), 32'hD);
    check("k9_held_pressed", 32'(kp.keypad_pressed), 32'h1);
    check("k9_nvalid", 32'(n_valid), 32'd1);
    keys[9] = 1'b0;
    step(3); check("k9_rel_pressed", 32'(kp.keypad_pressed), 32'h1);
    step(1); check("k9_rel_done", 32'(kp.keypad_pressed), 32'h0);
    check("k9_rel_col", 32'(kp.col_n), 32'hB);
    check("k9_code_kept", 32'(kp.key_code), 32'd9);

    // Two-tick glitch on key 0.
    step(2); check("gl_col0", 32'(kp.col_n), 32'hE);
    keys[0] = 1'b1;
    step(2); check("gl_frozen", 32'(kp.col_n), 32'hE);
    check("gl_pressed", 32'(kp.keypad_pressed), 32'h0);
    keys[0] = 1'b0;
    step(1); check("gl_resume", 32'(kp.col_n), 32'hD);
    check("gl_pressed_after", 32'(kp.keypad_pressed), 32'h0);
    check("gl_nvalid", 32'(n_valid), 32'd1);

    // Key 5 with release bounce.
    keys[5] = 1'b1;
    step(4); check("k5_valid", 32'(kp.key_valid), 32'h1);
    check("k5_code", 32'(kp.key_code), 32'd5);
    step(1); keys[5] = 1'b0;
    step(2); check("k5_bounce_pressed", 32'(kp.keypad_pressed), 32'h1);
    keys[5] = 1'b1;
    step(1); check("k5_back_pressed", 32'(kp.keypad_pressed), 32'h1);
    step(2); check("k5_nvalid", 32'(n_valid), 32'd2);
    keys[5] = 1'b0;
    step(4); check("k5_rel", 32'(kp.keypad_pressed), 32'h0);
    check("k5_rel_col", 32'(kp.col_n), 32'hB);

    // Rows 1 and 3 on column 2: lowest row wins.
    keys[6]  = 1'b1;
    keys[14] = 1'b1;
    step(4); check("k6_valid", 32'(kp.key_valid), 32'h1);
    check("k6_code", 32'(kp.key_code), 32'd6);
    // Extra keys during HELD, including one on the frozen column.
    keys[0] = 1'b1;
    keys[2] = 1'b1;
    step(3); check("roll_nvalid", 32'(n_valid), 32'd3);
    check("roll_code", 32'(kp.key_code), 32'd6);
    check("roll_col", 32'(kp.col_n), 32'hB);
    check("roll_pressed", 32'(kp.keypad_pressed), 32'h1);

    // Asynchronous reset mid-HELD.
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_col", 32'(kp.col_n), 32'hE);
    check("mid_rst_code", 32'(kp.key_code), 32'h0);
    check("mid_rst_valid", 32'(kp.key_valid), 32'h0);
    check("mid_rst_pressed", 32'(kp.keypad_pressed), 32'h0);
    keys[0] = 1'b0;
    keys[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    step(5); check("rr_frozen", 32'(kp.col_n), 32'hB);
    check("rr_pressed_early", 32'(kp.keypad_pressed), 32'h0);
    step(1); check("rr_valid", 32'(kp.key_valid), 32'h1);
    check("rr_code", 32'(kp.key_code), 32'd6);
    check("rr_pressed", 32'(kp.keypad_pressed), 32'h1);
    @(negedge clk);
    check("rr_pulse_end", 32'(kp.key_valid), 32'h0);
    check("rr_nvalid", 32'(n_valid - v0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
